// File: rtl/rocketcpu_wb_bridge.sv
// Byte-stream to Wishbone initiator: W/R/P command frames from a host link become single 32-bit bus transfers.
// One bus access per frame, bounded by TIMEOUT cycles without ack; reply bytes are held until the transmitter takes them.
module rocketcpu_wb_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_T = 8'h54;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t        state, state_n;
  logic          is_wr, is_wr_n;
  logic [1:0]    bcnt, bcnt_n;
  logic [31:0]   adr, adr_n, dat, dat_n;
  logic          cyc, cyc_n, we, we_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          tx_vld, tx_vld_n;
  logic [7:0]    tx_dat, tx_dat_n;
  logic [23:0]   rsp, rsp_n;
  logic [1:0]    rcnt, rcnt_n;

  always_ff @(posedge i_wb_clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      is_wr  <= 1'b0;
      bcnt   <= 2'd0;
      adr    <= 32'd0;
      dat    <= 32'd0;
      cyc    <= 1'b0;
      we     <= 1'b0;
      tmo    <= '0;
      tx_vld <= 1'b0;
      tx_dat <= 8'd0;
      rsp    <= 24'd0;
      rcnt   <= 2'd0;
    end else begin
      state  <= state_n;
      is_wr  <= is_wr_n;
      bcnt   <= bcnt_n;
      adr    <= adr_n;
      dat    <= dat_n;
      cyc    <= cyc_n;
      we     <= we_n;
      tmo    <= tmo_n;
      tx_vld <= tx_vld_n;
      tx_dat <= tx_dat_n;
      rsp    <= rsp_n;
      rcnt   <= rcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    is_wr_n  = is_wr;
    bcnt_n   = bcnt;
    adr_n    = adr;
    dat_n    = dat;
    cyc_n    = cyc;
    we_n     = we;
    tmo_n    = tmo;
    tx_vld_n = tx_vld;
    tx_dat_n = tx_dat;
    rsp_n    = rsp;
    rcnt_n   = rcnt;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          bcnt_n = 2'd0;
          case (i_rx_data)
            CMD_W: begin is_wr_n = 1'b1; state_n = ADDR; end
            CMD_R: begin is_wr_n = 1'b0; state_n = ADDR; end
            CMD_P: begin
              tx_vld_n = 1'b1;
              tx_dat_n = RSP_K;
              rcnt_n   = 2'd0;
              state_n  = RESP;
            end
            default: ;
          endcase
        end
      end
      ADDR: begin
        if (i_rx_valid) begin
          adr_n  = {adr[23:0], i_rx_data};
          bcnt_n = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            if (is_wr) begin
              state_n = DATA;
            end else begin
              state_n = BUS;
              cyc_n   = 1'b1;
              we_n    = 1'b0;
              tmo_n   = '0;
            end
          end
        end
      end
      DATA: begin
        if (i_rx_valid) begin
          dat_n  = {dat[23:0], i_rx_data};
          bcnt_n = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            state_n = BUS;
            cyc_n   = 1'b1;
            we_n    = 1'b1;
            tmo_n   = '0;
          end
        end
      end
      BUS: begin
        // An ack on the last permitted cycle still counts as success.
        if (i_wb_ack) begin
          cyc_n    = 1'b0;
          we_n     = 1'b0;
          tx_vld_n = 1'b1;
          state_n  = RESP;
          if (is_wr) begin
            tx_dat_n = RSP_K;
            rcnt_n   = 2'd0;
          end else begin
            tx_dat_n = i_wb_rdt[31:24];
            rsp_n    = i_wb_rdt[23:0];
            rcnt_n   = 2'd3;
          end
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          cyc_n    = 1'b0;
          we_n     = 1'b0;
          tx_vld_n = 1'b1;
          tx_dat_n = RSP_T;
          rcnt_n   = 2'd0;
          state_n  = RESP;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      RESP: begin
        if (tx_vld && i_tx_ready) begin
          if (rcnt == 2'd0) begin
            tx_vld_n = 1'b0;
            state_n  = IDLE;
          end else begin
            tx_dat_n = rsp[23:16];
            rsp_n    = {rsp[15:0], 8'h00};
            rcnt_n   = rcnt - 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_wb_adr   = adr;
  assign o_wb_dat   = dat;
  assign o_wb_sel   = 4'hF;
  assign o_wb_we    = we;
  assign o_wb_cyc   = cyc;
  assign o_tx_data  = tx_dat;
  assign o_tx_valid = tx_vld;
  assign o_busy     = (state != IDLE);
endmodule

// File: tb/tb_rocketcpu_wb_bridge.sv
// Directed frames feed expected bus transfers and reply bytes into queues; a negedge monitor pops and compares them.
module tb_rocketcpu_wb_bridge;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_wb_adr, o_wb_dat, i_wb_rdt;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, i_wb_ack, o_busy;

  rocketcpu_wb_bridge #(.TIMEOUT(TMO)) dut (
    .i_wb_clk(clk), .reset(rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; } bus_t;
  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Bus responder: small word memory, ack after ack_delay cycles of cyc (-1 = never).
  logic [31:0] mem [16];
  int ack_delay = 0;
  int cyc_cnt = 0;
  int bus_starts = 0;
  logic cyc_q = 1'b0;
  assign i_wb_rdt = mem[o_wb_adr[5:2]];
  assign i_wb_ack = o_wb_cyc && (ack_delay >= 0) && (cyc_cnt == ack_delay);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h12345678;
      mem[2] <= 32'hCAFEF00D;
    end else if (o_wb_cyc && i_wb_ack && o_wb_we) begin
      mem[o_wb_adr[5:2]] <= o_wb_dat;
    end
  end

  always @(posedge clk) begin
    cyc_cnt <= (o_wb_cyc && !i_wb_ack) ? cyc_cnt + 1 : 0;
    cyc_q   <= o_wb_cyc;
    if (o_wb_cyc && !cyc_q) bus_starts <= bus_starts + 1;
  end

  // Transmitter: 0 = always ready, 1 = one cycle on / three off, 2 = never ready.
  int ready_mode = 0;
  int rc = 0;
  always @(posedge clk) begin
    #1;
    rc = rc + 1;
    i_tx_ready = (ready_mode == 0) || (ready_mode == 1 && (rc % 4) == 0);
  end

  logic       tx_pend = 1'b0;
  logic [7:0] tx_prev = 8'd0;
  always @(negedge clk) begin
    bus_t e;
    logic [7:0] b;
    if (rst) begin
      tx_pend = 1'b0;
    end else begin
      if (o_wb_cyc && i_wb_ack) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected", o_wb_adr, 32'hFFFFFFFF);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_adr", o_wb_adr, e.adr);
          chk("bus_we", {31'b0, o_wb_we}, {31'b0, e.we});
          chk("bus_sel", {28'b0, o_wb_sel}, 32'hF);
          if (e.we) chk("bus_dat", o_wb_dat, e.dat);
        end
      end
      if (tx_pend) begin
        chk("tx_hold_valid", {31'b0, o_tx_valid}, 32'd1);
        chk("tx_hold_data", {24'b0, o_tx_data}, {24'b0, tx_prev});
      end
      if (o_tx_valid && i_tx_ready) begin
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", {24'b0, o_tx_data}, 32'hFFFFFFFF);
        end else begin
          b = exp_tx.pop_front();
          chk("tx_byte", {24'b0, o_tx_data}, {24'b0, b});
        end
      end
      tx_pend = o_tx_valid && !i_tx_ready;
      tx_prev = o_tx_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic exp_read(input logic [31:0] adr, input logic [31:0] d);
    exp_bus.push_back('{adr: adr, dat: 32'h0, we: 1'b0});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
  endtask

  task automatic exp_write(input logic [31:0] adr, input logic [31:0] d);
    exp_bus.push_back('{adr: adr, dat: d, we: 1'b1});
    exp_tx.push_back(8'h4B);
  endtask

  task automatic measure_cyc(output int n);
    n = 0;
    while (o_wb_cyc && n < 1000) begin n++; tick(); end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((o_busy || exp_tx.size() != 0 || exp_bus.size() != 0) && k < 3000) begin k++; tick(); end
    chk(name, {31'b0, o_busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"}, {31'b0, o_wb_cyc}, 32'd0);
    chk({tag, "_txv"}, {31'b0, o_tx_valid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    chk({tag, "_we"}, {31'b0, o_wb_we}, 32'd0);
    chk({tag, "_adr"}, o_wb_adr, 32'd0);
    chk({tag, "_dat"}, o_wb_dat, 32'd0);
    chk({tag, "_sel"}, {28'b0, o_wb_sel}, 32'hF);
    chk({tag, "_txd"}, {24'b0, o_tx_data}, 32'd0);
  endtask

  initial begin
    int n, m, s0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Write then read back, combinational ack: one bus cycle, four reply cycles.
    exp_write(32'h00000100, 32'hDEADBEEF);
    send_byte(8'h57); send_word(32'h00000100); send_word(32'hDEADBEEF);
    measure_cyc(n);
    chk("wr_cyc_len", n, 32'd1);
    wait_done("wr_idle");
    exp_read(32'h00000100, 32'hDEADBEEF);
    send_byte(8'h52); send_word(32'h00000100);
    measure_cyc(n);
    chk("rd_cyc_len", n, 32'd1);
    m = 0;
    while (o_tx_valid && m < 100) begin m++; tick(); end
    chk("rd_reply_cycles", m, 32'd4);
    wait_done("rd_idle");

    // Timeout: cyc held exactly TMO cycles, then a lone 'T'.
    ack_delay = -1;
    exp_tx.push_back(8'h54);
    send_byte(8'h52); send_word(32'h30000000);
    measure_cyc(n);
    chk("tmo_cyc_len", n, TMO);
    wait_done("tmo_idle");

    // Ack on the final permitted cycle wins over timeout, for read and write.
    ack_delay = TMO - 1;
    exp_read(32'h00000208, 32'hCAFEF00D);
    send_byte(8'h52); send_word(32'h00000208);
    measure_cyc(n);
    chk("late_rd_cyc_len", n, TMO);
    wait_done("late_rd_idle");
    exp_write(32'h0000020C, 32'h01020304);
    send_byte(8'h57); send_word(32'h0000020C); send_word(32'h01020304);
    wait_done("late_wr_idle");
    ack_delay = 0;

    // Transmit backpressure.
    ready_mode = 1;
    exp_read(32'h00000204, 32'h12345678);
    send_byte(8'h52); send_word(32'h00000204);
    wait_done("bp_idle");
    ready_mode = 0;

    // Junk bytes ignored, ping answered, no bus cycle.
    s0 = bus_starts;
    send_byte(8'h00);
    chk("junk00_busy", {31'b0, o_busy}, 32'd0);
    send_byte(8'hFF);
    chk("junkff_busy", {31'b0, o_busy}, 32'd0);
    exp_tx.push_back(8'h4B);
    send_byte(8'h50);
    chk("ping_txv", {31'b0, o_tx_valid}, 32'd1);
    wait_done("ping_idle");
    chk("ping_no_bus", bus_starts, s0);

    // Byte arriving during RESP is dropped.
    ready_mode = 2;
    exp_tx.push_back(8'h4B);
    send_byte(8'h50);
    tick();
    send_byte(8'h57);
    tick();
    ready_mode = 0;
    wait_done("resp_drop_idle");
    exp_read(32'h00000204, 32'h12345678);
    send_byte(8'h52); send_word(32'h00000204);
    wait_done("after_drop_idle");

    // Reset while the bus cycle is open.
    ack_delay = -1;
    send_byte(8'h52); send_word(32'h30000000);
    tick(); tick();
    chk("pre_rst_cyc", {31'b0, o_wb_cyc}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rst_bus");
    tick();
    rst = 1'b0;
    ack_delay = 0;
    tick();

    // Reset after two address bytes, then a clean write and readback.
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h11);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rst_frame");
    tick();
    rst = 1'b0;
    tick();
    exp_write(32'h0000010C, 32'hA5A55A5A);
    send_byte(8'h57); send_word(32'h0000010C); send_word(32'hA5A55A5A);
    wait_done("post_rst_wr_idle");
    exp_read(32'h0000010C, 32'hA5A55A5A);
    send_byte(8'h52); send_word(32'h0000010C);
    wait_done("post_rst_rd_idle");

    tick();
    chk("bus_queue_empty", exp_bus.size(), 32'd0);
    chk("tx_queue_empty", exp_tx.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
